next_pc_unit: RTL and testbench
===============================

Name: next_pc_unit

Overview:
- Owns the fetch program counter and produces the next fetch address each cycle.
- Sits directly downstream of the execute-stage 30-bit sign/zero extender: consumes its sign-extended word offset (imm30) to form branch targets.
- Also resolves jump and jump-register redirects.
- Drives instruction memory through a valid/ready handshake and issues a flush to the front end on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded on reset; bits [1:0] are ignored and treated as 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard stall from the pipeline; holds the PC.
- if_ready  input  1  instruction memory accepts the current pc this cycle.
- branch_taken  input  1  execute-stage branch resolved taken.
- imm30  input  30  sign-extended word offset from extender30.
- br_base  input  32  PC+4 of the branch/jump instruction in execute.
- jump  input  1  J/JAL in execute.
- jump_target  input  26  instr[25:0] of the jump.
- jr  input  1  JR/JALR in execute.
- jr_addr  input  32  register operand for jr; bits [1:0] ignored.
- pc  output  32  current fetch address; {pc_w, 2'b00}.
- pc_plus4  output  32  pc + 4, combinational from pc_w, mod 2^32.
- pc_valid  output  1  pc is a valid fetch request.
- flush  output  1  one-cycle pulse: squash IF/ID contents.

Behaviour:
- State: 30-bit word register pc_w. FSM states are BOOT, RUN and PENDING; PENDING is used only with DELAY_SLOT_EN.
- Reset (asynchronous): pc_w = RESET_PC[31:2], state = BOOT, pc_valid = 0, flush = 0, pending target cleared.
- BOOT:
  - pc_valid = 0.
  - The first clock edge after rst deasserts moves to RUN; pc_w is unchanged.
- RUN:
  - pc_valid = 1.
  - Accept = pc_valid & if_ready & ~stall.
- Redirect = jr | jump | branch_taken. Priority is jr > jump > branch; lower-priority requests in the same cycle are ignored.
- Target computation (word address):
  - jr: jr_addr[31:2].
  - jump: {br_base[31:28], jump_target}.
  - branch: br_base[31:2] + imm30, 30-bit add. Wraps mod 2^30 with no overflow flag.
- Next pc_w, without the option:
  - Redirect: pc_w <= target.
  - Else if accept: pc_w <= pc_w + 1, wrapping 30'h3FFF_FFFF -> 0.
  - Else: pc_w holds.
- Redirect overrides both stall and if_ready; a redirect is never lost.
- flush is a registered output: high in the cycle after any redirect edge, low otherwise.
- Redirect while in BOOT is ignored.
- Latency: a redirect asserted in cycle N appears on pc in cycle N+1. Sequential advance also has 1-cycle latency.
- pc and pc_valid are stable while pc_valid=1 and if_ready=0; the handshake holds the request.
- Mid-operation reset behaves as the reset above: pending target discarded, state returns to BOOT.

Optional Feature:
- Macro: DELAY_SLOT_EN. Implements MIPS architectural branch delay slots.
- Enabled:
  - A redirect in RUN captures the target into pend_w and moves to PENDING; pc_w does not jump.
  - In PENDING, the next accept advances sequentially (fetch of the delay slot) and on the same edge loads pc_w <= pend_w, returning to RUN. The delay slot is never lost.
  - Any redirect seen while in PENDING is dropped; a branch in a delay slot is unsupported.
  - flush is tied to 0.
  - Reset clears PENDING.
- Disabled: no PENDING state and no pend_w register; redirect behaves as described in Behaviour, with flush pulses.

Test Plan:
- Reset release, RESET_PC=32'h0040_0000, if_ready=1 -> pc_valid=0 for one cycle, then pc = 0x0040_0000, 0x0040_0004, 0x0040_0008 on successive cycles.
- if_ready=0 for 3 cycles at pc=0x100 -> pc stays 0x100 and pc_valid stays 1; stall=1 behaves identically; both released -> 0x104.
- Branch: branch_taken=1, br_base=0x204, imm30=30'h3FFF_FFFE (-2) -> next pc=0x1FC, flush=1 for exactly one cycle. With stall=1 in the same cycle -> same result.
- Simultaneous jr=1 (jr_addr=0x8000_0003), jump=1, branch_taken=1 -> pc=0x8000_0000.
- Jump: jump_target=26'h000_0010, br_base=0xA000_0004 -> pc=0xA000_0040. Sequential wrap: pc=0xFFFF_FFFC with accept -> pc=0x0000_0000.
- DELAY_SLOT_EN: branch at pc=0x300 to 0x400 -> pc sequence 0x300, 0x304, 0x400 and flush never asserts. Second redirect in PENDING -> ignored. rst asserted in PENDING -> pc=RESET_PC, no jump to 0x400.

Source files
------------

// File: rtl/next_pc_if.sv
// Fetch request bus between the next-PC unit and instruction memory:
// the requested address, its valid/ready handshake and the front-end flush.
interface next_pc_if;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        if_ready;
  logic        flush;

  modport master (
    output pc,
    output pc_plus4,
    output pc_valid,
    output flush,
    input  if_ready
  );

  modport slave (
    input  pc,
    input  pc_plus4,
    input  pc_valid,
    input  flush,
    output if_ready
  );
endinterface

// File: rtl/next_pc_unit.sv
// Fetch program counter: sequential advance, branch/jump/jr redirects and IF/ID flush.
// Define DELAY_SLOT_EN for MIPS delay slots (redirect deferred one fetch, no flush).
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic signed [29:0] imm30,
  input  logic [31:0]        br_base,
  input  logic               jump,
  input  logic [25:0]        jump_target,
  input  logic               jr,
  input  logic [31:0]        jr_addr,
  next_pc_if.master          bus
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
`ifdef DELAY_SLOT_EN
    PENDING = 2'd2,
`endif
    RUN     = 2'd1
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] pc_w, pc_d;
  logic [29:0] target;
  logic        redirect;
  logic        accept;
  logic        unused;

  // Word-address branch target; the offset is two's complement and wraps mod 2^30.
  function automatic logic [29:0] branch_word(input logic [29:0] base,
                                              input logic signed [29:0] off);
    return base + $unsigned(off);
  endfunction

  assign redirect = jr | jump | branch_taken;
  assign unused   = ^{jr_addr[1:0], br_base[1:0]};

  always_comb begin
    target = branch_word(br_base[31:2], imm30);
    if (jr)
      target = jr_addr[31:2];
    else if (jump)
      target = {br_base[31:28], jump_target};
  end

  assign bus.pc_valid = (state_q != BOOT);
  assign bus.pc       = {pc_w, 2'b00};
  assign bus.pc_plus4 = {pc_w + 30'd1, 2'b00};
  assign accept       = bus.pc_valid & bus.if_ready & ~stall;

`ifdef DELAY_SLOT_EN
  logic [29:0] pend_w, pend_d;

  assign bus.flush = 1'b0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_w;
    pend_d  = pend_w;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (accept)
          pc_d = pc_w + 30'd1;
        if (redirect) begin
          pend_d  = target;
          state_d = PENDING;
        end
      end
      // The delay slot fetch is the accept that releases the deferred target.
      PENDING: begin
        if (accept) begin
          pc_d    = pend_w;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_w    <= RESET_PC[31:2];
      pend_w  <= '0;
    end else begin
      state_q <= state_d;
      pc_w    <= pc_d;
      pend_w  <= pend_d;
    end
  end
`else
  logic flush_q, flush_d;

  assign bus.flush = flush_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_w;
    flush_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      // Redirect wins over stall and if_ready so a resolved branch is never lost.
      RUN: begin
        if (redirect) begin
          pc_d    = target;
          flush_d = 1'b1;
        end else if (accept) begin
          pc_d = pc_w + 30'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_w    <= RESET_PC[31:2];
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_w    <= pc_d;
      flush_q <= flush_d;
    end
  end
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit; expectations queued per clock, checked after the edge.
module tb_next_pc_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall;
  logic               branch_taken;
  logic signed [29:0] imm30;
  logic [31:0]        br_base;
  logic               jump;
  logic [25:0]        jump_target;
  logic               jr;
  logic [31:0]        jr_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
  } exp_t;

  exp_t sb[$];

  next_pc_if bus ();

  next_pc_unit #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .imm30        (imm30),
    .br_base      (br_base),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_now(input string tag, input logic [31:0] p, input logic v, input logic f);
    chk({tag, ".pc"}, bus.pc, p);
    chk({tag, ".valid"}, {31'd0, bus.pc_valid}, {31'd0, v});
    chk({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, f});
  endtask

  // Queue what the outputs must be after the coming edge, then compare them.
  task automatic tick(input string tag, input logic [31:0] p, input logic v, input logic f);
    exp_t e;
    e.tag = tag; e.pc = p; e.valid = v; e.flush = f;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_now(e.tag, e.pc, e.valid, e.flush);
  endtask

  task automatic clr();
    stall = 0; branch_taken = 0; jump = 0; jr = 0;
  endtask

  initial begin
    rst = 1; clr();
    bus.if_ready = 1;
    imm30 = '0; br_base = '0; jump_target = '0; jr_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    chk_now("reset", RPC, 1'b0, 1'b0);
    rst = 0;
    chk_now("boot", RPC, 1'b0, 1'b0);
    tick("run0", RPC, 1'b1, 1'b0);
    tick("seq1", RPC + 32'd4, 1'b1, 1'b0);
    tick("seq2", RPC + 32'd8, 1'b1, 1'b0);

`ifndef DELAY_SLOT_EN
    jump = 1; br_base = 32'h0; jump_target = 26'h40;
    tick("jmp100", 32'h100, 1'b1, 1'b1);
    clr(); bus.if_ready = 0;
    chk("plus4_100", bus.pc_plus4, 32'h104);
    for (int i = 0; i < 3; i++) tick("ifrdy_hold", 32'h100, 1'b1, 1'b0);
    bus.if_ready = 1; stall = 1;
    for (int i = 0; i < 3; i++) tick("stall_hold", 32'h100, 1'b1, 1'b0);
    stall = 0;
    tick("release", 32'h104, 1'b1, 1'b0);

    branch_taken = 1; br_base = 32'h204; imm30 = 30'h3FFF_FFFE;
    tick("br_back", 32'h1FC, 1'b1, 1'b1);
    clr();
    tick("br_after", 32'h200, 1'b1, 1'b0);
    branch_taken = 1; stall = 1; bus.if_ready = 0;
    tick("br_stall", 32'h1FC, 1'b1, 1'b1);
    clr(); bus.if_ready = 1;
    tick("br_stall_after", 32'h200, 1'b1, 1'b0);

    jr = 1; jr_addr = 32'h8000_0003; jump = 1; jump_target = 26'h10; branch_taken = 1;
    tick("prio_jr", 32'h8000_0000, 1'b1, 1'b1);
    clr();
    tick("prio_after", 32'h8000_0004, 1'b1, 1'b0);

    jump = 1; jump_target = 26'h000_0010; br_base = 32'hA000_0004;
    tick("jump", 32'hA000_0040, 1'b1, 1'b1);
    clr(); jump = 1; br_base = 32'hA000_0004; branch_taken = 1; imm30 = 30'd100;
    tick("prio_jump", 32'hA000_0040, 1'b1, 1'b1);
    clr(); jr = 1; jr_addr = 32'hFFFF_FFFC;
    tick("to_top", 32'hFFFF_FFFC, 1'b1, 1'b1);
    clr();
    chk("plus4_wrap", bus.pc_plus4, 32'h0000_0000);
    tick("wrap", 32'h0000_0000, 1'b1, 1'b0);
`else
    jump = 1; br_base = 32'h0; jump_target = 26'hC0;
    tick("ds_jmp_slot", RPC + 32'd12, 1'b1, 1'b0);
    clr();
    tick("ds_jmp_300", 32'h300, 1'b1, 1'b0);
    branch_taken = 1; br_base = 32'h304; imm30 = 30'h3F;
    tick("ds_slot_304", 32'h304, 1'b1, 1'b0);
    clr(); stall = 1;
    tick("ds_pend_stall", 32'h304, 1'b1, 1'b0);
    stall = 0;
    tick("ds_tgt_400", 32'h400, 1'b1, 1'b0);
    branch_taken = 1; br_base = 32'h404; imm30 = 30'h3F;
    tick("ds_slot_404", 32'h404, 1'b1, 1'b0);
    clr(); jr = 1; jr_addr = 32'h700;
    tick("ds_drop_jr", 32'h500, 1'b1, 1'b0);
    clr(); branch_taken = 1; br_base = 32'h504; imm30 = 30'h3FFF_FFBF;
    tick("ds_slot_504", 32'h504, 1'b1, 1'b0);
    clr(); bus.if_ready = 0;
    #2 rst = 1; #1;
    chk_now("ds_rst_pend", RPC, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 0; bus.if_ready = 1;
    tick("ds_rst_run", RPC, 1'b1, 1'b0);
    tick("ds_rst_seq", RPC + 32'd4, 1'b1, 1'b0);
`endif

    // Asynchronous reset mid-run, with a redirect held through BOOT.
    #2 rst = 1; #1;
    chk_now("midrst", RPC, 1'b0, 1'b0);
    jump = 1; br_base = 32'h0; jump_target = 26'h123;
    @(posedge clk); #1;
    rst = 0;
    tick("boot_ignore", RPC, 1'b1, 1'b0);
    clr();
    tick("boot_seq", RPC + 32'd4, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
